// File: rtl/seq_wide_adder_ctrl_pkg.sv
// Shared definitions for sequenced adders: FSM encoding and slice width.
package seq_wide_adder_ctrl_pkg;

  localparam int SLICE_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/seq_wide_adder_ctrl_add5.sv
// 5-bit ripple-carry adder slice, built from full-adder cells.
module seq_wide_adder_ctrl_add5
  import seq_wide_adder_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               Cin,
  output logic [SLICE_W-1:0] Sum,
  output logic               Cout
);

  logic c;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    c   = Cin;
    Sum = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      Sum[i] = A[i] ^ B[i] ^ c;
      c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end

endmodule

// File: rtl/seq_wide_adder_ctrl.sv
// Wide A+B+Cin built by feeding one shared 5-bit adder one slice per clock,
// LSB slice first, with the inter-slice carry kept in a register.
module seq_wide_adder_ctrl
  import seq_wide_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NSLICES = WIDTH / SLICE_W;
  localparam int CW      = $clog2(NSLICES) + 1;

  generate
    if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
      $error("seq_wide_adder_ctrl: WIDTH must be a positive multiple of 5");
    end
  endgenerate

  seq_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             amsb_q, bmsb_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic               accept;
  logic               last;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic [WIDTH-1:0]   sum_shift;

  assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign accept = ready & start;
  assign last   = (cnt_q == CW'(NSLICES - 1));

  seq_wide_adder_ctrl_add5 u_add5 (
    .A    (opa_q[SLICE_W-1:0]),
    .B    (opb_q[SLICE_W-1:0]),
    .Cin  (carry_q),
    .Sum  (slice_sum),
    .Cout (slice_cout)
  );

  // New slice enters at the top so after NSLICES passes the result is aligned.
  generate
    if (NSLICES == 1) begin : g_one
      assign sum_shift = slice_sum;
    end else begin : g_many
      assign sum_shift = {slice_sum, sum_q[WIDTH-1:SLICE_W]};
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, slice stepping and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      opa_q   <= A;
      opb_q   <= B;
      carry_q <= Cin;
      amsb_q  <= A[WIDTH-1];
      bmsb_q  <= B[WIDTH-1];
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      sum_q   <= sum_shift;
      opa_q   <= opa_q >> SLICE_W;
      opb_q   <= opb_q >> SLICE_W;
      carry_q <= slice_cout;
      if (last) begin
        // Final slice: its MSB is the result sign bit.
        cout_q <= slice_cout;
        ovf_q  <= (amsb_q ~^ bmsb_q) & (slice_sum[SLICE_W-1] ^ amsb_q);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// Self-checking bench for seq_wide_adder_ctrl (WIDTH=20, four slices).
module tb_seq_wide_adder_ctrl;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Cin = 1'b0;
  logic         ready, busy, done, Cout, Ovf;
  logic [W-1:0] Sum;

  int checks = 0;
  int failures = 0;

  seq_wide_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .ready(ready), .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition and signed range test.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] t;
    int sa, sb, tot;
    t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s  = t[W-1:0];
    co = t[W];
    sa = int'($signed(a));
    sb = int'($signed(b));
    tot = sa + sb + int'(c);
    ov = (tot > (2**(W-1)) - 1) || (tot < -(2**(W-1)));
  endfunction

  // Waits (bounded) for done, counting posedges from the accepting edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] s, output logic co, output logic ov, output int lat);
    @(negedge clk);
    A = a; B = b; Cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    wait_done(lat);
    s = Sum; co = Cout; ov = Ovf;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit chk_lat);
    logic [W-1:0] s, es;
    logic co, ov, eco, eov;
    int lat;
    model(a, b, c, es, eco, eov);
    run_op(a, b, c, s, co, ov, lat);
    checks++;
    if (s !== es || co !== eco || ov !== eov) begin
      failures++;
      $display("FAIL %s: A=%h B=%h Cin=%b got Sum=%h Cout=%b Ovf=%b want Sum=%h Cout=%b Ovf=%b",
               name, a, b, c, s, co, ov, es, eco, eov);
    end
    if (chk_lat) begin
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL %s_latency: got %0d want 4", name, lat);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (Sum !== '0 || Cout !== 1'b0 || Ovf !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: Sum=%h Cout=%b Ovf=%b done=%b busy=%b ready=%b want 0/0/0/0/0/1",
               Sum, Cout, Ovf, done, busy, ready);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    check_op("basic", 20'h12345, 20'h00FFF, 1'b0, 1'b1);
  endtask

  task automatic test_carry();
    check_op("carry_ripple", 20'hFFFFF, 20'h00001, 1'b0, 1'b1);
    check_op("cin_only", 20'h00000, 20'h00000, 1'b1, 1'b0);
    check_op("all_ones_cin", 20'hFFFFF, 20'hFFFFF, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    check_op("ovf_pos", 20'h7FFFF, 20'h00001, 1'b0, 1'b0);
    check_op("ovf_neg", 20'h80000, 20'h80000, 1'b0, 1'b0);
    check_op("ovf_cin", 20'h7FFFF, 20'h00000, 1'b1, 1'b0);
    check_op("no_ovf_mixed", 20'h80000, 20'hFFFFF, 1'b1, 1'b0);
  endtask

  // start pulsed mid-RUN with other operands must be ignored.
  task automatic test_handshake();
    logic [W-1:0] es, s;
    logic eco, eov;
    int nbusy, ndone;
    model(20'h0ABCD, 20'h01111, 1'b0, es, eco, eov);
    s = '0; nbusy = 0; ndone = 0;
    @(negedge clk);
    A = 20'h0ABCD; B = 20'h01111; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy) nbusy++;
      if (done) begin ndone++; s = Sum; end
      if (i == 1) begin A = 20'h55555; B = 20'h33333; Cin = 1'b1; start = 1'b1; end
      if (i == 2) start = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (s !== es) begin
      failures++;
      $display("FAIL handshake_sum: got %h want %h", s, es);
    end
    checks++;
    if (nbusy !== 4) begin
      failures++;
      $display("FAIL handshake_busy_cycles: got %0d want 4", nbusy);
    end
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL handshake_done_cycles: got %0d want 1", ndone);
    end
  endtask

  // start held through DONE; the second op is taken in the DONE cycle.
  task automatic test_back_to_back();
    logic [W-1:0] e1, e2, s1, s2;
    logic c1, c2, o1, o2;
    int lat1, lat2;
    model(20'h12345, 20'h54321, 1'b1, e1, c1, o1);
    model(20'hF0F0F, 20'h0F0F1, 1'b0, e2, c2, o2);
    @(negedge clk);
    A = 20'h12345; B = 20'h54321; Cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    A = 20'hF0F0F; B = 20'h0F0F1; Cin = 1'b0;
    wait_done(lat1);
    s1 = Sum;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat2);
    s2 = Sum;
    checks++;
    if (s1 !== e1 || lat1 !== 4) begin
      failures++;
      $display("FAIL b2b_first: got Sum=%h lat=%0d want Sum=%h lat=4", s1, lat1, e1);
    end
    checks++;
    if (s2 !== e2 || Cout !== c2 || lat2 !== 4) begin
      failures++;
      $display("FAIL b2b_second: got Sum=%h Cout=%b lat=%0d want Sum=%h Cout=%b lat=4",
               s2, Cout, lat2, e2, c2);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    A = 20'hFFFFF; B = 20'hFFFFF; Cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Sum !== '0 || Cout !== 1'b0 || Ovf !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_midop: Sum=%h Cout=%b Ovf=%b ready=%b busy=%b done=%b want 0/0/0/1/0/0",
               Sum, Cout, Ovf, ready, busy, done);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    check_op("after_reset", 20'h2468A, 20'h13579, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s, es;
    logic c, co, ov, eco, eov;
    int lat, nbad;
    nbad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      if (i % 50 == 0) a = {1'b0, {(W-1){1'b1}}};
      if (i % 70 == 0) b = {1'b1, {(W-1){1'b0}}};
      model(a, b, c, es, eco, eov);
      run_op(a, b, c, s, co, ov, lat);
      checks++;
      if (s !== es || co !== eco || ov !== eov || lat !== 4) begin
        failures++;
        nbad++;
        if (nbad <= 10)
          $display("FAIL random[%0d]: A=%h B=%h Cin=%b got %h/%b/%b lat=%0d want %h/%b/%b lat=4",
                   i, a, b, c, s, co, ov, lat, es, eco, eov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_handshake();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
